// File: rtl/sample_deserializer_pkg.sv
// Shared defaults and width helpers for the sample deserializer and its FIFO.
// Pure declarations: no latency, no flow control.
// Keeps parameter-derived widths identical between the top and the bench.
package sample_deserializer_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int NUM_UNITS_DEF  = 2;

    // Index width for a counter over n values, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int bytes_per_sample(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/sample_fifo2.sv
// Two-entry sample FIFO holding assembled data plus its destination unit tag.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: head held while pop_rdy is low; a push into a full FIFO is taken only alongside a pop.
module sample_fifo2
    import sample_deserializer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int UNIT_W     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_vld,
    input  logic [DATA_WIDTH-1:0] push_dat,
    input  logic [UNIT_W-1:0]     push_unit,
    output logic                  pop_vld,
    input  logic                  pop_rdy,
    output logic [DATA_WIDTH-1:0] pop_dat,
    output logic [UNIT_W-1:0]     pop_unit,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem_dat  [2];
    logic [UNIT_W-1:0]     mem_unit [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic                  pop;
    logic                  push;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign pop_vld  = !empty;
    assign pop_dat  = mem_dat[rd_ptr];
    assign pop_unit = mem_unit[rd_ptr];
    assign pop      = pop_vld && pop_rdy;
    // Full-and-popping frees the head slot in the same edge, so the push lands there.
    assign push     = push_vld && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_dat[0]  <= '0;
            mem_dat[1]  <= '0;
            mem_unit[0] <= '0;
            mem_unit[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                mem_dat[wr_ptr]  <= push_dat;
                mem_unit[wr_ptr] <= push_unit;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sample_deserializer.sv
// Assembles MSB-first bytes into samples tagged round-robin with a detector unit index.
// Latency: sample_valid rises one cycle after the last byte; frame_err/overflow pulse one cycle after their cause.
// Backpressure: 2-entry FIFO; with it full and no pop, a completed sample is dropped and overflow pulses.
module sample_deserializer
    import sample_deserializer_pkg::*;
#(
    parameter int NUM_UNITS      = NUM_UNITS_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [7:0]                        byte_in,
    input  logic                              byte_valid,
    output logic [DATA_WIDTH-1:0]             sample_data,
    output logic [idx_width(NUM_UNITS)-1:0]   sample_unit,
    output logic                              sample_valid,
    input  logic                              sample_ready,
    output logic                              frame_err,
    output logic                              overflow
);

    localparam int BYTES_PER_SAMPLE = bytes_per_sample(DATA_WIDTH);
    localparam int UNIT_W           = idx_width(NUM_UNITS);
    localparam int IDX_W            = idx_width(BYTES_PER_SAMPLE);
    localparam int TO_W             = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BYTES_PER_SAMPLE - 1);
    localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(NUM_UNITS - 1);
    localparam logic [TO_W-1:0]   IDLE_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [IDX_W-1:0]      byte_idx;
    logic [UNIT_W-1:0]     unit_cnt;
    logic [TO_W-1:0]       idle_cnt;
    logic [DATA_WIDTH-9:0] shift_reg;
    logic [DATA_WIDTH-1:0] assembled;
    logic                  last_byte;
    logic                  expire;
    logic                  drop;
    logic                  fifo_full;
    logic                  fifo_empty;

    assign assembled = {shift_reg, byte_in};
    assign last_byte = byte_valid && (byte_idx == IDX_LAST);
    // An arriving byte always wins over the expiry that would otherwise fire this cycle.
    assign expire    = !byte_valid && (byte_idx != '0) && (idle_cnt == IDLE_LAST);
    assign drop      = last_byte && fifo_full && !(sample_ready && !fifo_empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx  <= '0;
            unit_cnt  <= '0;
            idle_cnt  <= '0;
            shift_reg <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= expire;
            overflow  <= drop;
            if (byte_valid) begin
                shift_reg <= assembled[DATA_WIDTH-9:0];
                idle_cnt  <= '0;
                if (last_byte) begin
                    byte_idx <= '0;
                    // Counter advances even when the sample is dropped.
                    unit_cnt <= (unit_cnt == UNIT_LAST) ? '0 : unit_cnt + UNIT_W'(1);
                end else begin
                    byte_idx <= byte_idx + IDX_W'(1);
                end
            end else if (expire) begin
                byte_idx  <= '0;
                unit_cnt  <= '0;
                idle_cnt  <= '0;
                shift_reg <= '0;
            end else if (byte_idx != '0) begin
                idle_cnt <= idle_cnt + TO_W'(1);
            end
        end
    end

    sample_fifo2 #(
        .DATA_WIDTH (DATA_WIDTH),
        .UNIT_W     (UNIT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_vld  (last_byte),
        .push_dat  (assembled),
        .push_unit (unit_cnt),
        .pop_vld   (sample_valid),
        .pop_rdy   (sample_ready),
        .pop_dat   (sample_data),
        .pop_unit  (sample_unit),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: doc/sample_deserializer.md
SAMPLE_DESERIALIZER -- requirements
Module: sample_deserializer

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 2: number of time-interleaved detector units fed round-robin.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: sample width in bits; a multiple of 8, at least 16.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: idle cycles allowed between bytes of one sample.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port byte_in, input, 8 bits: data byte, MSB-first within a sample, driven from uio_in.
REQ-007 SHALL have port byte_valid, input, 1 bit: one byte accepted per cycle high, driven from ui_in[2].
REQ-008 SHALL have port sample_data, output, DATA_WIDTH bits: assembled signed sample at the FIFO head.
REQ-009 SHALL have port sample_unit, output, max(1,clog2(NUM_UNITS)) bits: destination unit index of the head sample.
REQ-010 SHALL have port sample_valid, output, 1 bit: FIFO non-empty.
REQ-011 SHALL have port sample_ready, input, 1 bit: consumer accepts the head when sample_valid and sample_ready are both high.
REQ-012 SHALL have port frame_err, output, 1 bit: one-cycle pulse on timeout discard of a partial sample.
REQ-013 SHALL have port overflow, output, 1 bit: one-cycle pulse when a completed sample is dropped.

Function
REQ-014 SHALL keep a byte index, 0..DATA_WIDTH/8-1; each accepted byte shifts in at the LSB end and increments the index.
REQ-015 SHALL complete a sample on the byte with index DATA_WIDTH/8-1, then return the index to 0.
REQ-016 SHALL tag each completed sample with the current unit counter, then advance the counter modulo NUM_UNITS (NUM_UNITS-1 wraps to 0).
REQ-017 SHALL push the completed sample into a 2-entry FIFO; sample_valid rises the cycle after the last byte is accepted (latency 1).
REQ-018 SHALL present the FIFO head on sample_data/sample_unit, stable while sample_valid is high and sample_ready is low.
REQ-019 SHALL, when the FIFO is full and no pop occurs that cycle, drop the completed sample, pulse overflow, and still advance the unit counter.
REQ-020 SHALL accept a push into a full FIFO when a pop occurs the same cycle; in that case no overflow is raised.
REQ-021 SHALL treat a simultaneous push and pop on an empty FIFO as a push only; a sample is never bypassed in the same cycle.
REQ-022 SHALL count idle cycles only while byte index ≠ 0; the counter clears on every accepted byte.
REQ-023 SHALL, when the idle count reaches TIMEOUT_CYCLES, discard the partial sample, set byte index and unit counter to 0, and pulse frame_err.
REQ-024 SHALL give an accepted byte priority over timeout expiry in the same cycle: the byte is taken and no frame_err pulse occurs.
REQ-025 SHALL not flush FIFO contents on timeout.

Reset
REQ-026 SHALL, with rst_n low, asynchronously clear byte index, unit counter, idle counter, shift register, and FIFO pointers.
REQ-027 SHALL drive these outputs during reset: sample_valid=0, sample_data=0, sample_unit=0, frame_err=0, overflow=0.
REQ-028 SHALL discard any partial sample when reset is asserted mid-sample; the first byte after release is an MSB.

Structure
REQ-029 SHALL take BYTES_PER_SAMPLE and the unit-index width from a shared package, the same package that holds the top-layer DATA_WIDTH/NUM_UNITS defaults.
REQ-030 SHALL implement the 2-entry FIFO as sub-module sample_fifo2 (data plus unit tag, valid/ready pop, full/empty flags).

Verification
REQ-031 SHALL cover basic assembly: bytes 0x12,0x34 on consecutive cycles -> next cycle sample_valid=1, sample_data=0x1234, sample_unit=0.
REQ-032 SHALL cover interleaving: four samples 0x0001,0x0002,0x0003,0x0004 with sample_ready=1 -> units 0,1,0,1 in order.
REQ-033 SHALL cover backpressure: sample_ready=0, three samples sent -> first two retained in order, overflow pulses once on the third, unit counter reads 1 afterwards.
REQ-034 SHALL cover timeout: byte 0xAB, then 255 idle cycles -> frame_err pulses once; then bytes 0xCD,0xEF -> 0xCDEF with unit 0.
REQ-035 SHALL cover reset mid-sample: byte 0x55, rst_n low for 2 cycles, then bytes 0x01,0x02 -> 0x0102, unit 0, no frame_err.
REQ-036 SHALL cover the byte-versus-timeout tie: a byte arrives exactly on the expiry cycle -> no frame_err, sample completes normally.
